// File: rtl/rs232_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rs232_tx_arbiter
// Brief    : Round-robin sharing of one RS232 transmitter among N requesters,
//            sequencing send strobe / sent pulse / requester ack.
//            Optional watchdog enabled by defining RS232_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module rs232_tx_arbiter #(
    parameter int N       = 4,
    parameter int BITS    = 16,
    parameter int IDW     = 2,
    parameter int HOLD    = 24,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*BITS-1:0] req_data,
    output logic [N-1:0]      ack,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic              tx_send,
    output logic [BITS-1:0]   tx_data,
    input  logic              tx_sent,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int              c_HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD - 1);
    localparam logic [IDW:0]    c_N         = (IDW + 1)'(N);
    localparam logic [IDW-1:0]  c_LAST_ID   = IDW'(N - 1);
    localparam logic [N-1:0]    c_ONE       = N'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_grant_id;
    logic [BITS-1:0]   r_tx_data;
    logic              r_tx_send;
    logic [N-1:0]      r_ack;
    logic [2:0]        r_sync;
    logic              r_sent_seen;
    logic [c_HW-1:0]   r_hold_cnt;

    logic              w_sent_edge;
    logic              w_sent_any;
    logic              w_timeout;
    logic              w_grant;
    logic              w_enter_done;
    logic [IDW:0]      w_idx;
    logic [IDW-1:0]    w_winner;
    logic [BITS-1:0]   w_words [N];

    for (genvar g = 0; g < N; g++) begin : g_words
        assign w_words[g] = req_data[g*BITS +: BITS];
    end

    assign w_sent_edge = r_sync[1] & ~r_sync[2];
    assign w_sent_any  = w_sent_edge | r_sent_seen;

    // Scan from the highest offset down so the offset closest to r_ptr wins.
    always_comb begin
        w_idx    = '0;
        w_winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_ptr} + (IDW + 1)'(i);
            if (w_idx >= c_N) begin
                w_idx = w_idx - c_N;
            end
            if (req[w_idx[IDW-1:0]]) begin
                w_winner = w_idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_sent_any || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_enter_done = (r_state != S_DONE) && (w_state_nxt == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= '0;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_tx_data   <= '0;
            r_tx_send   <= 1'b0;
            r_ack       <= '0;
            r_sent_seen <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[1:0], tx_sent};
            r_ack  <= w_enter_done ? (c_ONE << r_grant_id) : '0;

            if (w_grant) begin
                r_grant_id <= w_winner;
                r_tx_data  <= w_words[w_winner];
                r_tx_send  <= 1'b1;
                r_hold_cnt <= '0;
            end else if (r_state == S_SEND) begin
                if (w_state_nxt != S_SEND) begin
                    r_tx_send <= 1'b0;
                end else begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end
            end

            // A sent pulse that overlaps the strobe must not be lost.
            if (r_state == S_SEND && w_sent_edge) begin
                r_sent_seen <= 1'b1;
            end else if (r_state == S_DONE || r_state == S_IDLE) begin
                r_sent_seen <= 1'b0;
            end

            if (r_state == S_DONE) begin
                r_ptr <= (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;
            end
        end
    end

`ifdef RS232_ARB_TIMEOUT_EN
    localparam int              c_TW      = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT - 1);

    logic [c_TW-1:0] r_to_cnt;
    logic            r_timeout_err;
    logic            w_in_xfer;

    assign w_in_xfer = (r_state == S_SEND) || (r_state == S_WAIT);
    assign w_timeout = w_in_xfer && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_to_cnt      <= w_in_xfer ? r_to_cnt + 1'b1 : '0;
            r_timeout_err <= w_timeout && !w_sent_any;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    // Watchdog absent: TIMEOUT has no effect and the error port stays low.
    assign timeout_err = 1'b0 & (TIMEOUT > 0);
`endif

    assign ack      = r_ack;
    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant_id;
    assign tx_send  = r_tx_send;
    assign tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_rs232_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs232_tx_arbiter
// Brief    : Directed self-checking bench for rs232_tx_arbiter (N=4, HOLD=24,
//            TIMEOUT=64); honours RS232_ARB_TIMEOUT_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_rs232_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic        tx_send;
    logic [15:0] tx_data;
    logic        tx_sent;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] words [4];

    rs232_tx_arbiter #(
        .N       (4),
        .BITS    (16),
        .IDW     (2),
        .HOLD    (24),
        .TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .busy        (busy),
        .grant_id    (grant_id),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_sent     (tx_sent),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst     = 1'b1;
        req     = 4'b0000;
        tx_sent = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One complete transfer with a sent pulse once the strobe has dropped.
    task automatic run_xfer(input logic [3:0] r, input bit drop,
                            output logic [1:0] gid, output logic [15:0] td,
                            output logic [3:0] ackv, output logic [3:0] ack_next,
                            output bit ok);
        int lat;
        int w;
        ok   = 1'b1;
        lat  = 0;
        ackv = '0;
        req  = r;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (tx_send) begin
                lat = k;
                break;
            end
        end
        if (lat != 1) ok = 1'b0;
        gid = grant_id;
        td  = tx_data;
        w = 0;
        while (tx_send && w < 40) begin
            tick();
            w++;
        end
        if (tx_send) ok = 1'b0;
        tx_sent = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) tx_sent = 1'b0;
            if (|ack) begin
                ackv = ack;
                break;
            end
        end
        tx_sent = 1'b0;
        if (drop) req = 4'b0000;
        tick();
        ack_next = ack;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++; if (ack !== 4'b0000) $display("FAIL reset_ack got=%b want=0000", ack); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL reset_gid got=%0d want=0", grant_id); else n_pass++;
        n_checks++; if (tx_send !== 1'b0) $display("FAIL reset_send got=%b want=0", tx_send); else n_pass++;
        n_checks++; if (tx_data !== 16'h0000) $display("FAIL reset_data got=%h want=0000", tx_data); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_terr got=%b want=0", timeout_err); else n_pass++;
    endtask

    task automatic test_single;
        int first, cnt, last, ackc, acks;
        logic [15:0] td;
        logic [3:0] av;
        logic bz;
        do_reset();
        first = 0; cnt = 0; last = 0; td = '0; bz = 1'b0;
        req = 4'b0001;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (tx_send) begin
                if (first == 0) first = c;
                cnt++;
                last = c;
            end
            if (c == 1) begin
                td = tx_data;
                bz = busy;
            end
        end
        n_checks++; if (first !== 1) $display("FAIL single_send_first got=%0d want=1", first); else n_pass++;
        n_checks++; if (cnt !== 24) $display("FAIL single_send_len got=%0d want=24", cnt); else n_pass++;
        n_checks++; if (last !== 24) $display("FAIL single_send_last got=%0d want=24", last); else n_pass++;
        n_checks++; if (td !== 16'hA55A) $display("FAIL single_data got=%h want=a55a", td); else n_pass++;
        n_checks++; if (bz !== 1'b1) $display("FAIL single_busy got=%b want=1", bz); else n_pass++;
        // Cycle 1 is the one in which tx_sent rises.
        tx_sent = 1'b1;
        ackc = 0; acks = 0; av = '0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 2) tx_sent = 1'b0;
            if (|ack) begin
                if (acks == 0) begin
                    ackc = c + 1;
                    av   = ack;
                end
                acks++;
                req = 4'b0000;
            end
        end
        n_checks++; if (ackc !== 4) $display("FAIL single_ack_cycle got=%0d want=4", ackc); else n_pass++;
        n_checks++; if (av !== 4'b0001) $display("FAIL single_ack_val got=%b want=0001", av); else n_pass++;
        n_checks++; if (acks !== 1) $display("FAIL single_ack_count got=%0d want=1", acks); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy got=%b want=0", busy); else n_pass++;
    endtask

    task automatic test_round_robin;
        logic [1:0] gid;
        logic [15:0] td;
        logic [3:0] av, an;
        bit ok;
        logic [1:0] exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp = 2'(i % 4);
            run_xfer(4'b1111, (i == 4), gid, td, av, an, ok);
            n_checks++; if (ok !== 1'b1) $display("FAIL rr_handshake[%0d] got=%b want=1", i, ok); else n_pass++;
            n_checks++; if (gid !== exp) $display("FAIL rr_gid[%0d] got=%0d want=%0d", i, gid, exp); else n_pass++;
            n_checks++; if (td !== words[exp]) $display("FAIL rr_data[%0d] got=%h want=%h", i, td, words[exp]); else n_pass++;
            n_checks++; if (av !== (4'b0001 << exp)) $display("FAIL rr_ack[%0d] got=%b want=%b", i, av, 4'b0001 << exp); else n_pass++;
            n_checks++; if (an !== 4'b0000) $display("FAIL rr_ack_pulse[%0d] got=%b want=0000", i, an); else n_pass++;
        end
    endtask

    task automatic test_ptr_subset;
        logic [1:0] gid;
        logic [15:0] td;
        logic [3:0] av, an;
        bit ok;
        do_reset();
        run_xfer(4'b0010, 1'b1, gid, td, av, an, ok);
        n_checks++; if (gid !== 2'd1) $display("FAIL sub_setup_gid got=%0d want=1", gid); else n_pass++;
        run_xfer(4'b0011, 1'b0, gid, td, av, an, ok);
        n_checks++; if (gid !== 2'd0) $display("FAIL sub_first_gid got=%0d want=0", gid); else n_pass++;
        n_checks++; if (av !== 4'b0001) $display("FAIL sub_first_ack got=%b want=0001", av); else n_pass++;
        run_xfer(4'b0011, 1'b1, gid, td, av, an, ok);
        n_checks++; if (gid !== 2'd1) $display("FAIL sub_second_gid got=%0d want=1", gid); else n_pass++;
        n_checks++; if (av !== 4'b0010) $display("FAIL sub_second_ack got=%b want=0010", av); else n_pass++;
        n_checks++; if (ok !== 1'b1) $display("FAIL sub_handshake got=%b want=1", ok); else n_pass++;
    endtask

    task automatic test_sent_during_send;
        int cnt, last, ackc, acks;
        do_reset();
        cnt = 0; last = 0; ackc = 0; acks = 0;
        req = 4'b0001;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 5) tx_sent = 1'b1;
            if (c == 7) tx_sent = 1'b0;
            if (tx_send) begin
                cnt++;
                last = c;
            end
            if (|ack) begin
                if (acks == 0) ackc = c;
                acks++;
                req = 4'b0000;
            end
        end
        n_checks++; if (cnt !== 24) $display("FAIL early_send_len got=%0d want=24", cnt); else n_pass++;
        n_checks++; if (last !== 24) $display("FAIL early_send_last got=%0d want=24", last); else n_pass++;
        n_checks++; if (ackc !== 26) $display("FAIL early_ack_cycle got=%0d want=26", ackc); else n_pass++;
        n_checks++; if (acks !== 1) $display("FAIL early_ack_count got=%0d want=1", acks); else n_pass++;
    endtask

    task automatic test_stray_sent;
        int acks;
        logic [1:0] gid;
        logic [15:0] td;
        logic [3:0] av, an;
        bit ok;
        do_reset();
        tx_sent = 1'b1;
        tick(); tick();
        tx_sent = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        req = 4'b0100;
        acks = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (|ack) acks++;
        end
        n_checks++; if (acks !== 0) $display("FAIL stray_ack_count got=%0d want=0", acks); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL stray_busy got=%b want=1", busy); else n_pass++;
        run_xfer(4'b0100, 1'b1, gid, td, av, an, ok);
        n_checks++; if (av !== 4'b0100) $display("FAIL stray_late_ack got=%b want=0100", av); else n_pass++;
    endtask

    task automatic test_reset_in_wait;
        int w, acks;
        logic [1:0] gid;
        logic [15:0] td;
        logic [3:0] av, an;
        bit ok;
        do_reset();
        run_xfer(4'b0010, 1'b1, gid, td, av, an, ok);
        req = 4'b0100;
        tick();
        w = 0;
        while (tx_send && w < 40) begin
            tick();
            w++;
        end
        tick(); tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL rstw_pre_busy got=%b want=1", busy); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++; if ({ack, busy, grant_id, tx_send, tx_data, timeout_err} !== 25'd0)
            $display("FAIL rstw_outputs got=%b/%b/%0d/%b/%h/%b want=all zero", ack, busy, grant_id, tx_send, tx_data, timeout_err);
        else n_pass++;
        rst = 1'b0;
        req = 4'b0000;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (|ack) acks++;
        end
        n_checks++; if (acks !== 0) $display("FAIL rstw_no_ack got=%0d want=0", acks); else n_pass++;
        req = 4'b1111;
        tick();
        n_checks++; if (grant_id !== 2'd0) $display("FAIL rstw_regrant got=%0d want=0", grant_id); else n_pass++;
        n_checks++; if (tx_data !== 16'hA55A) $display("FAIL rstw_data got=%h want=a55a", tx_data); else n_pass++;
    endtask

    task automatic test_timeout;
        int ackc, errc, acks;
        logic [3:0] av;
        do_reset();
        req = 4'b0001;
        ackc = 0; errc = 0; acks = 0; av = '0;
`ifdef RS232_ARB_TIMEOUT_EN
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (timeout_err && errc == 0) errc = c;
            if (|ack) begin
                if (acks == 0) begin
                    ackc = c;
                    av   = ack;
                end
                acks++;
                req = 4'b0000;
            end
        end
        n_checks++; if (ackc !== 65) $display("FAIL to_ack_cycle got=%0d want=65", ackc); else n_pass++;
        n_checks++; if (errc !== 65) $display("FAIL to_err_cycle got=%0d want=65", errc); else n_pass++;
        n_checks++; if (av !== 4'b0001) $display("FAIL to_ack_val got=%b want=0001", av); else n_pass++;
        n_checks++; if (acks !== 1) $display("FAIL to_ack_count got=%0d want=1", acks); else n_pass++;
`else
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (timeout_err) errc++;
            if (|ack) acks++;
        end
        n_checks++; if (busy !== 1'b1) $display("FAIL noto_busy got=%b want=1", busy); else n_pass++;
        n_checks++; if (errc !== 0) $display("FAIL noto_err_count got=%0d want=0", errc); else n_pass++;
        n_checks++; if (acks !== 0) $display("FAIL noto_ack_count got=%0d want=0", acks); else n_pass++;
        n_checks++; if (ackc !== 0 || av !== 4'b0000) $display("FAIL noto_ack_seen got=%0d want=0", ackc); else n_pass++;
`endif
        do_reset();
    endtask

    initial begin
        words[0] = 16'hA55A;
        words[1] = 16'h1234;
        words[2] = 16'hBEEF;
        words[3] = 16'h0F0F;
        req_data = {words[3], words[2], words[1], words[0]};
        rst      = 1'b1;
        req      = 4'b0000;
        tx_sent  = 1'b0;

        test_reset();
        test_single();
        test_round_robin();
        test_ptr_subset();
        test_sent_during_send();
        test_stray_sent();
        test_reset_in_wait();
        test_timeout();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
